// File: rtl/pong_pkg.sv
// Shared field geometry, ball FSM state encoding and paddle hit test for the pong datapath.
package pong_pkg;

  localparam int FIELD_W  = 128;
  localparam int FIELD_H  = 96;
  localparam int PADDLE_W = 16;
  localparam int CENTER_X = FIELD_W / 2;
  localparam int CENTER_Y = FIELD_H / 2;

  typedef enum logic [1:0] {
    ST_SERVE  = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  // Span is [pos-8, pos+7]; 9-bit signed keeps the span from wrapping at either field edge.
  function automatic logic paddle_hit(input logic [6:0] pos, input logic [6:0] x);
    logic signed [8:0] w_lo;
    logic signed [8:0] w_hi;
    logic signed [8:0] w_xs;
    w_lo = $signed({2'b00, pos}) - $signed(9'(PADDLE_W / 2));
    w_hi = $signed({2'b00, pos}) + $signed(9'(PADDLE_W / 2 - 1));
    w_xs = $signed({2'b00, x});
    return (w_xs >= w_lo) && (w_xs <= w_hi);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Rate divider: single-cycle tick every CLK_HZ/RATE_HZ clocks, counter wraps after the tick cycle.
module tick_gen #(
  parameter int CLK_HZ  = 10_000_000,
  parameter int RATE_HZ = 60
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CUENTA = CLK_HZ / RATE_HZ;
  localparam int CW     = (CUENTA > 1) ? $clog2(CUENTA) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(CUENTA - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ball_logic.sv
// Ball motion, paddle/wall reflection, miss detection and scoring; all state advances on movement ticks.
// SERVE: ball at centre, counting ticks | PLAY: one step per tick | SCORED: hold miss spot one tick | OVER: frozen until rst
module ball_logic
  import pong_pkg::*;
#(
  parameter int CLK_HZ      = 10_000_000,
  parameter int BALL_HZ     = 60,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] pos_p0,
  input  logic [6:0] pos_p1,
  output logic [6:0] ball_x,
  output logic [6:0] ball_y,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       point,
  output logic       game_over
);

  localparam int          SW         = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [6:0]  X_MAX      = 7'(FIELD_W - 1);
  localparam logic [6:0]  Y_TOP_HIT  = 7'd1;
  localparam logic [6:0]  Y_BOT_HIT  = 7'(FIELD_H - 2);

  logic w_tick;

  state_t        r_state, w_state_nx;
  logic [6:0]    r_x, w_x_nx;
  logic [6:0]    r_y, w_y_nx;
  logic          r_dx_neg, w_dx_neg_nx;
  logic          r_dy_neg, w_dy_neg_nx;
  logic          r_launch_neg, w_launch_neg_nx;
  logic          r_serve_up, w_serve_up_nx;
  logic [SW-1:0] r_serve_cnt, w_serve_cnt_nx;
  logic [3:0]    r_score0, w_score0_nx;
  logic [3:0]    r_score1, w_score1_nx;
  logic          r_point, w_point_nx;
  logic          r_game_over, w_game_over_nx;

  logic signed [7:0] w_dxv, w_dyv, w_xn, w_yn;
  logic              w_wall;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .RATE_HZ (BALL_HZ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_dxv  = r_dx_neg ? -8'sd1 : 8'sd1;
  assign w_dyv  = r_dy_neg ? -8'sd1 : 8'sd1;
  assign w_wall = (r_x == X_MAX && !r_dx_neg) || (r_x == 7'd0 && r_dx_neg);

  always_comb begin
    w_state_nx      = r_state;
    w_x_nx          = r_x;
    w_y_nx          = r_y;
    w_dx_neg_nx     = r_dx_neg;
    w_dy_neg_nx     = r_dy_neg;
    w_launch_neg_nx = r_launch_neg;
    w_serve_up_nx   = r_serve_up;
    w_serve_cnt_nx  = r_serve_cnt;
    w_score0_nx     = r_score0;
    w_score1_nx     = r_score1;
    w_point_nx      = 1'b0;
    w_game_over_nx  = r_game_over;
    w_xn            = $signed({1'b0, r_x}) + w_dxv;
    w_yn            = $signed({1'b0, r_y}) + w_dyv;

    if (w_tick) begin
      case (r_state)
        ST_SERVE: begin
          if (r_serve_cnt == SERVE_LAST) begin
            w_state_nx      = ST_PLAY;
            w_serve_cnt_nx  = '0;
            w_dx_neg_nx     = r_launch_neg;
            w_launch_neg_nx = ~r_launch_neg;
            w_dy_neg_nx     = r_serve_up;
          end else begin
            w_serve_cnt_nx = r_serve_cnt + 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_wall) begin
            w_dx_neg_nx = ~r_dx_neg;
            w_xn        = $signed({1'b0, r_x}) - w_dxv;
          end
          w_x_nx = w_xn[6:0];
          // Paddle test uses the pre-move column.
          if (r_y == Y_TOP_HIT && r_dy_neg) begin
            if (paddle_hit(pos_p0, r_x)) begin
              w_dy_neg_nx = 1'b0;
            end else begin
              w_y_nx        = 7'd0;
              w_score1_nx   = r_score1 + 4'd1;
              w_point_nx    = 1'b1;
              w_serve_up_nx = 1'b1;
              w_state_nx    = ST_SCORED;
            end
          end else if (r_y == Y_BOT_HIT && !r_dy_neg) begin
            if (paddle_hit(pos_p1, r_x)) begin
              w_dy_neg_nx = 1'b1;
            end else begin
              w_y_nx        = 7'(FIELD_H - 1);
              w_score0_nx   = r_score0 + 4'd1;
              w_point_nx    = 1'b1;
              w_serve_up_nx = 1'b0;
              w_state_nx    = ST_SCORED;
            end
          end else begin
            w_y_nx = w_yn[6:0];
          end
        end
        ST_SCORED: begin
          if (r_score0 == 4'(WIN_SCORE) || r_score1 == 4'(WIN_SCORE)) begin
            w_state_nx     = ST_OVER;
            w_game_over_nx = 1'b1;
          end else begin
            w_state_nx     = ST_SERVE;
            w_serve_cnt_nx = '0;
            w_x_nx         = 7'(CENTER_X);
            w_y_nx         = 7'(CENTER_Y);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_SERVE;
      r_x          <= 7'(CENTER_X);
      r_y          <= 7'(CENTER_Y);
      r_dx_neg     <= 1'b0;
      r_dy_neg     <= 1'b0;
      r_launch_neg <= 1'b0;
      r_serve_up   <= 1'b0;
      r_serve_cnt  <= '0;
      r_score0     <= 4'd0;
      r_score1     <= 4'd0;
      r_point      <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_x          <= w_x_nx;
      r_y          <= w_y_nx;
      r_dx_neg     <= w_dx_neg_nx;
      r_dy_neg     <= w_dy_neg_nx;
      r_launch_neg <= w_launch_neg_nx;
      r_serve_up   <= w_serve_up_nx;
      r_serve_cnt  <= w_serve_cnt_nx;
      r_score0     <= w_score0_nx;
      r_score1     <= w_score1_nx;
      r_point      <= w_point_nx;
      r_game_over  <= w_game_over_nx;
    end
  end

  assign ball_x    = r_x;
  assign ball_y    = r_y;
  assign score0    = r_score0;
  assign score1    = r_score1;
  assign point     = r_point;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_ball_logic.sv
// Scoreboard bench: a per-tick game model queues expected outputs each clock; a monitor compares on the falling edge.
module tb_ball_logic;

  localparam int CLK_HZ      = 100;
  localparam int BALL_HZ     = 10;
  localparam int SERVE_TICKS = 2;
  localparam int WIN         = 7;
  localparam int PERIOD      = CLK_HZ / BALL_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] pos_p0 = 7'd64;
  logic [6:0] pos_p1 = 7'd64;
  logic [6:0] ball_x, ball_y;
  logic [3:0] score0, score1;
  logic       point, game_over;

  always #5 clk = ~clk;

  ball_logic #(
    .CLK_HZ      (CLK_HZ),
    .BALL_HZ     (BALL_HZ),
    .SERVE_TICKS (SERVE_TICKS),
    .WIN_SCORE   (WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pos_p0    (pos_p0),
    .pos_p1    (pos_p1),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .score0    (score0),
    .score1    (score1),
    .point     (point),
    .game_over (game_over)
  );

  typedef struct {
    int x; int y; int s0; int s1; int pt; int go;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e;
  int n_checks = 0;
  int n_pass   = 0;

  // Game model: plain integer positions and directions, one update per tick.
  int m_x, m_y, m_dx, m_dy, m_s0, m_s1, m_pt;
  int m_launch_dx, m_serve_dy, m_serve_left, m_cyc;
  bit m_serving, m_scored, m_over;

  function automatic bit covers(int pos, int x);
    return (x >= pos - 8) && (x <= pos + 7);
  endfunction

  task automatic model_reset();
    m_x = 64; m_y = 48; m_dx = 1; m_dy = 1; m_s0 = 0; m_s1 = 0; m_pt = 0;
    m_launch_dx = 1; m_serve_dy = 1; m_serve_left = SERVE_TICKS; m_cyc = 0;
    m_serving = 1; m_scored = 0; m_over = 0;
  endtask

  task automatic model_tick(int p0, int p1);
    int nx;
    if (m_over) begin
    end else if (m_scored) begin
      m_scored = 0;
      if (m_s0 == WIN || m_s1 == WIN) m_over = 1;
      else begin
        m_serving = 1; m_serve_left = SERVE_TICKS; m_x = 64; m_y = 48;
      end
    end else if (m_serving) begin
      m_serve_left--;
      if (m_serve_left == 0) begin
        m_serving = 0; m_dx = m_launch_dx; m_launch_dx = -m_launch_dx; m_dy = m_serve_dy;
      end
    end else begin
      nx = m_x + m_dx;
      if (nx < 0 || nx > 127) begin m_dx = -m_dx; nx = m_x + m_dx; end
      if (m_y == 1 && m_dy == -1) begin
        if (covers(p0, m_x)) m_dy = 1;
        else begin m_y = 0; m_s1++; m_pt = 1; m_serve_dy = -1; m_scored = 1; end
      end else if (m_y == 94 && m_dy == 1) begin
        if (covers(p1, m_x)) m_dy = -1;
        else begin m_y = 95; m_s0++; m_pt = 1; m_serve_dy = 1; m_scored = 1; end
      end else begin
        m_y = m_y + m_dy;
      end
      m_x = nx;
    end
  endtask

  task automatic model_edge(bit r, int p0, int p1);
    if (r) model_reset();
    else begin
      m_pt = 0;
      m_cyc++;
      if (m_cyc % PERIOD == 0) model_tick(p0, p1);
    end
  endtask

  // Mostly near the ball (hit or near-miss), sometimes anywhere, sometimes the low edge case.
  function automatic int pick(int x);
    int r, off, p;
    r = int'($urandom_range(0, 99));
    if (r < 15) return int'($urandom_range(0, 127));
    if (r < 20) return 2;
    off = int'($urandom_range(0, 24)) - 12;
    p = x + off;
    if (p < 0) p = 0;
    if (p > 127) p = 127;
    return p;
  endfunction

  task automatic step(input bit next_rst);
    snap_t s;
    @(posedge clk);
    model_edge(rst, int'(pos_p0), int'(pos_p1));
    s.x = m_x; s.y = m_y; s.s0 = m_s0; s.s1 = m_s1; s.pt = m_pt; s.go = int'(m_over);
    exp_q.push_back(s);
    #1;
    rst    = next_rst;
    pos_p0 = 7'(pick(m_x));
    pos_p1 = 7'(pick(m_x));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if (int'(ball_x) == mon_e.x && int'(ball_y) == mon_e.y && int'(score0) == mon_e.s0 &&
            int'(score1) == mon_e.s1 && int'(point) == mon_e.pt && int'(game_over) == mon_e.go)
          n_pass++;
        else
          $display("FAIL outputs t=%0t got x=%0d y=%0d s0=%0d s1=%0d pt=%0d go=%0d want x=%0d y=%0d s0=%0d s1=%0d pt=%0d go=%0d",
                   $time, ball_x, ball_y, score0, score1, point, game_over,
                   mon_e.x, mon_e.y, mon_e.s0, mon_e.s1, mon_e.pt, mon_e.go);
      end
    end
  end

  initial begin
    int n;
    model_reset();
    step(1);
    step(1);
    step(0);
    n = 0;
    while (!m_over && n < 60000) begin
      step(0);
      n++;
    end
    n_checks++;
    if (game_over === 1'b1) n_pass++;
    else $display("FAIL game_over_reached got %0b want 1 after %0d cycles", game_over, n);
    repeat (35) step(0);
    step(1);
    step(0);
    repeat (700) step(0);
    while (m_cyc % PERIOD != PERIOD - 2) step(0);
    step(1);
    step(0);
    repeat (60) step(0);
    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
